// File: rtl/inst_loader.sv
// Instruction loader: buffers one host program and replays it as a gap-free burst to the PE instruction memory.
// Optional build macro INST_LOADER_REPLAY_EN adds a HOLD state that allows the stored program to be re-issued.
module inst_loader #(
  parameter int INST_W = 64,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [INST_W-1:0] s_data,
  input  logic              s_last,
  output logic              inst_out_v,
  output logic [INST_W-1:0] inst_out,
  input  logic              exec_v,
  input  logic              replay,
  output logic              busy,
  output logic [LEN_W-1:0]  prog_len,
  output logic              trunc_err
);

  localparam logic [2:0] S_FILL    = 3'd0;
  localparam logic [2:0] S_BURST   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
`ifdef INST_LOADER_REPLAY_EN
  localparam logic [2:0] S_HOLD    = 3'd4;
`endif

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_wcnt;
  logic [LEN_W-1:0]  r_rptr;
  logic [LEN_W-1:0]  r_len;
  logic              r_ready;
  logic              r_trunc;
  logic              r_out_v;
  logic [INST_W-1:0] r_out;
  logic [INST_W-1:0] r_mem [DEPTH];

  logic              w_replay;
  logic              w_hs;
  logic              w_full_beat;
  logic              w_fill_end;
  logic              w_last_rd;
  logic              w_ready_nxt;
  logic              w_wait_done;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;

`ifdef INST_LOADER_REPLAY_EN
  assign w_replay    = (r_state == S_HOLD) & replay;
  assign w_ready_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_HOLD);
  assign busy        = (r_state != S_FILL) && (r_state != S_HOLD);
`else
  logic w_unused;
  assign w_unused    = replay;
  assign w_replay    = 1'b0;
  assign w_ready_nxt = (w_state_nxt == S_FILL);
  assign busy        = (r_state != S_FILL);
`endif

  // Replay wins over a host beat offered in the same HOLD cycle.
  assign w_hs        = s_valid & r_ready & ~w_replay;
  assign w_full_beat = (r_wcnt == LAST_IDX);
  assign w_fill_end  = w_hs & (s_last | w_full_beat);
  assign w_last_rd   = (r_rptr == (r_len - LEN_W'(1)));
  assign w_wait_done = (r_state == S_WAIT_LO) & ~exec_v;
  assign w_waddr     = r_wcnt[ADDR_W-1:0];
  assign w_raddr     = r_rptr[ADDR_W-1:0];

  assign s_ready     = r_ready;
  assign inst_out_v  = r_out_v;
  assign inst_out    = r_out;
  assign prog_len    = r_len;
  assign trunc_err   = r_trunc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:    if (w_fill_end) w_state_nxt = S_BURST;
      S_BURST:   if (w_last_rd) w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (exec_v) w_state_nxt = S_WAIT_LO;
`ifdef INST_LOADER_REPLAY_EN
      S_WAIT_LO: if (!exec_v) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_replay || w_fill_end) w_state_nxt = S_BURST;
        else if (w_hs)              w_state_nxt = S_FILL;
      end
`else
      S_WAIT_LO: if (!exec_v) w_state_nxt = S_FILL;
`endif
      default:   w_state_nxt = S_FILL;
    endcase
  end

  // Buffer RAM: written on every accepted beat, never reset.
  always_ff @(posedge clk) begin
    if (w_hs) r_mem[w_waddr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_ready <= 1'b0;
      r_wcnt  <= '0;
      r_rptr  <= '0;
      r_len   <= '0;
      r_trunc <= 1'b0;
      r_out_v <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;

      if (w_wait_done)  r_wcnt <= '0;
      else if (w_hs)    r_wcnt <= r_wcnt + LEN_W'(1);

      if (w_fill_end) r_len <= r_wcnt + LEN_W'(1);
      if (w_hs && w_full_beat && !s_last) r_trunc <= 1'b1;

      if (w_fill_end || w_replay)  r_rptr <= '0;
      else if (r_state == S_BURST) r_rptr <= r_rptr + LEN_W'(1);

      // Output stage: one registered word per BURST read, zero otherwise.
      r_out_v <= (r_state == S_BURST);
      r_out   <= (r_state == S_BURST) ? r_mem[w_raddr] : '0;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: a per-cycle schedule of expected burst words plus directed checks.
module tb_inst_loader;
  localparam int INST_W = 64;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 5;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [INST_W-1:0] s_data;
  logic              s_last;
  logic              inst_out_v;
  logic [INST_W-1:0] inst_out;
  logic              exec_v;
  logic              replay;
  logic              busy;
  logic [LEN_W-1:0]  prog_len;
  logic              trunc_err;

  inst_loader #(.INST_W(INST_W), .DEPTH(DEPTH), .ADDR_W(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .inst_out_v(inst_out_v), .inst_out(inst_out),
    .exec_v(exec_v), .replay(replay),
    .busy(busy), .prog_len(prog_len), .trunc_err(trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit done = 0;
  logic [INST_W-1:0] exp_word [int];
  logic [INST_W-1:0] prog_w [32];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a program whose final beat is accepted in cycle t appears on inst_out in cycles t+2 .. t+1+n.
  always @(negedge clk) begin
    if (!done) begin
      if (exp_word.exists(cyc)) begin
        check("burst_v", {63'd0, inst_out_v}, 64'd1);
        check("burst_data", inst_out, exp_word[cyc]);
      end else begin
        check("idle_v", {63'd0, inst_out_v}, 64'd0);
        check("idle_data", inst_out, 64'd0);
      end
    end
  end

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (cyc != target) check("wait_cyc", 64'(cyc), 64'(target));
  endtask

  task automatic send_prog(input int n, input bit with_last, output int t_last);
    int k;
    t_last = cyc;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = prog_w[i];
      s_last  = with_last && (i == n - 1);
      k = 0;
      while (!s_ready && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (!s_ready) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
      t_last = cyc;
      if (i == n - 1)
        for (int j = 0; j < n; j++) exp_word[t_last + 2 + j] = prog_w[j];
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic exec_pulse(input int n);
    exec_v = 1'b1;
    repeat (n) @(negedge clk);
    exec_v = 1'b0;
  endtask

  int t;
  int c;

  initial begin
    rst_n = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; exec_v = 1'b0; replay = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_prog_len", 64'(prog_len), 64'd0);
    check("rst_trunc", {63'd0, trunc_err}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_s_ready", {63'd0, s_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // 3-word program, exec_v held low
    prog_w[0] = 64'h11; prog_w[1] = 64'h22; prog_w[2] = 64'h33;
    send_prog(3, 1'b1, t);
    check("p1_s_ready_off", {63'd0, s_ready}, 64'd0);
    check("p1_busy", {63'd0, busy}, 64'd1);
    check("p1_no_early_v", {63'd0, inst_out_v}, 64'd0);
    wait_cyc(t + 2);
    check("p1_first", inst_out, 64'h11);
    wait_cyc(t + 4);
    check("p1_third", inst_out, 64'h33);
    wait_cyc(t + 5);
    check("p1_end_v", {63'd0, inst_out_v}, 64'd0);
    check("p1_len", 64'(prog_len), 64'd3);
    repeat (8) @(negedge clk);
    check("p1_wait_busy", {63'd0, busy}, 64'd1);
    check("p1_wait_ready", {63'd0, s_ready}, 64'd0);

    // host word offered while blocked must survive into the next program
    s_valid = 1'b1; s_data = 64'h44; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("holdoff_ready", {63'd0, s_ready}, 64'd0);
    exec_pulse(5);
    @(negedge clk);
    check("p2_fill_ready", {63'd0, s_ready}, 64'd1);
    check("p2_fill_busy", {63'd0, busy}, 64'd0);
    prog_w[0] = 64'h44; prog_w[1] = 64'h55;
    send_prog(2, 1'b1, t);
    wait_cyc(t + 4);
    check("p2_no_stale", {63'd0, inst_out_v}, 64'd0);
    check("p2_len", 64'(prog_len), 64'd2);
    exec_pulse(3);
    repeat (2) @(negedge clk);

    // 16 words, no s_last -> truncation
    for (int i = 0; i < DEPTH; i++) prog_w[i] = 64'h1000 + 64'(i);
    send_prog(DEPTH, 1'b0, t);
    check("p3_trunc_set", {63'd0, trunc_err}, 64'd1);
    wait_cyc(t + 17);
    check("p3_last_word", inst_out, 64'h100F);
    wait_cyc(t + 18);
    check("p3_end_v", {63'd0, inst_out_v}, 64'd0);
    check("p3_len", 64'(prog_len), 64'd16);
    exec_pulse(2);
    repeat (2) @(negedge clk);

    // single-word program
    prog_w[0] = 64'hABCD;
    send_prog(1, 1'b1, t);
    wait_cyc(t + 2);
    check("p4_word", inst_out, 64'hABCD);
    wait_cyc(t + 3);
    check("p4_end_v", {63'd0, inst_out_v}, 64'd0);
    check("p4_len", 64'(prog_len), 64'd1);
    check("p4_trunc_sticky", {63'd0, trunc_err}, 64'd1);
    exec_pulse(2);
    repeat (2) @(negedge clk);

    // reset during the second burst cycle of a 4-word program
    prog_w[0] = 64'h71; prog_w[1] = 64'h72; prog_w[2] = 64'h73; prog_w[3] = 64'h74;
    send_prog(4, 1'b1, t);
    wait_cyc(t + 3);
    #2;
    exp_word.delete();
    rst_n = 1'b0;
    #1;
    check("rst_mid_v", {63'd0, inst_out_v}, 64'd0);
    check("rst_mid_data", inst_out, 64'd0);
    check("rst_mid_trunc", {63'd0, trunc_err}, 64'd0);
    check("rst_mid_len", 64'(prog_len), 64'd0);
    check("rst_mid_ready", {63'd0, s_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("p5_ready", {63'd0, s_ready}, 64'd1);
    prog_w[0] = 64'h81; prog_w[1] = 64'h82;
    send_prog(2, 1'b1, t);
    wait_cyc(t + 4);
    check("p5_len", 64'(prog_len), 64'd2);
    check("p5_end_v", {63'd0, inst_out_v}, 64'd0);
    exec_pulse(2);
    repeat (2) @(negedge clk);

`ifdef INST_LOADER_REPLAY_EN
    prog_w[0] = 64'h5; prog_w[1] = 64'h6;
    send_prog(2, 1'b1, t);
    wait_cyc(t + 4);
    exec_pulse(2);
    repeat (2) @(negedge clk);
    check("hold_busy", {63'd0, busy}, 64'd0);
    check("hold_ready", {63'd0, s_ready}, 64'd1);
    replay = 1'b1;
    c = cyc;
    exp_word[c + 2] = 64'h5;
    exp_word[c + 3] = 64'h6;
    @(negedge clk);
    replay = 1'b0;
    wait_cyc(c + 2);
    check("replay_first", inst_out, 64'h5);
    wait_cyc(c + 4);
    check("replay_end_v", {63'd0, inst_out_v}, 64'd0);
    check("replay_len", 64'(prog_len), 64'd2);
    exec_pulse(2);
    repeat (2) @(negedge clk);
    prog_w[0] = 64'h9;
    send_prog(1, 1'b1, t);
    wait_cyc(t + 3);
    check("hold_new_len", 64'(prog_len), 64'd1);
    check("hold_new_end_v", {63'd0, inst_out_v}, 64'd0);
`endif

    repeat (5) @(negedge clk);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream feeder for the PE instruction memory.
- Accepts instruction words from the host over a valid/ready stream and buffers one complete program. It then replays that program as a single gap-free `inst_out_v` burst, which is what the instruction memory needs for its write phase and its delayed execute trigger.
- After the burst it blocks new input until the instruction memory finishes its execution pass, so programs never overlap.

Parameters:
- INST_W, 64, instruction word width; must equal the instruction-memory word width.
- DEPTH, 16, program buffer entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- LEN_W, 5, width of length counters; holds values 0..DEPTH.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, host instruction word valid.
- s_ready, output, 1, loader can accept a word this cycle.
- s_data, input, INST_W, host instruction word.
- s_last, input, 1, marks the final word of a program; qualified by s_valid & s_ready.
- inst_out_v, output, 1, burst valid; drives the instruction memory's write-valid input.
- inst_out, output, INST_W, burst instruction word.
- exec_v, input, 1, instruction-memory read-valid output; high while the program executes.
- replay, input, 1, re-issue the stored program (used only with the optional feature).
- busy, output, 1, high in every state except FILL.
- prog_len, output, LEN_W, length of the last captured program.
- trunc_err, output, 1, sticky: a program hit DEPTH words without s_last.

Behaviour:
- Reset: clk and the asynchronous active-low rst_n are fixed as stated above. rst_n low forces the following immediately (asynchronously):
  - outputs: s_ready=0, inst_out_v=0, inst_out=0, busy=0, prog_len=0, trunc_err=0;
  - internal: FSM=FILL, write pointer=0, read pointer=0, burst counter=0.
  - Buffer RAM contents are not reset.
  - Reset mid-burst drops inst_out_v in the same instant and discards the program.
- FSM states: FILL, BURST, WAIT_HI, WAIT_LO.
- FILL:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) writes s_data at the write pointer, then increments the pointer.
  - If the accepted beat has s_last=1, or is the DEPTH-th word, then next cycle: prog_len = words accepted, state=BURST, s_ready=0, read pointer=0.
  - A DEPTH-th word without s_last sets trunc_err; trunc_err clears only on reset.
  - exec_v is ignored in FILL.
- BURST:
  - Reads one entry per cycle. Outputs are registered: inst_out_v and inst_out are valid one cycle after each read.
  - inst_out_v is high for exactly prog_len consecutive cycles, with no gaps.
  - inst_out = 0 whenever inst_out_v=0.
  - After the last read, go to WAIT_HI.
- WAIT_HI: wait for exec_v=1, then go to WAIT_LO.
- WAIT_LO: wait for exec_v=0.
  - Without the optional feature: reset the write pointer to 0 and go to FILL.
  - With the optional feature: see below.
- Latency: s_last accepted at cycle t → state BURST at t+1 → first inst_out_v at t+2 → last inst_out_v at t+1+prog_len.
- Ordering: words are emitted in accept order, and s_data is never altered.
- Input hold-off: s_ready=0 in BURST, WAIT_HI and WAIT_LO. Host words presented then are held off and never dropped.
- Single-word program: a first beat with s_last=1 gives prog_len=1 and exactly one inst_out_v cycle.
- If exec_v never rises, the loader stays in WAIT_HI indefinitely with busy=1. This is legal and has no timeout.
- s_valid while s_ready=0 has no effect. s_last on a non-handshake cycle is ignored.

Optional Feature:
- Macro: INST_LOADER_REPLAY_EN.
- Defined:
  - WAIT_LO exits to a fifth state, HOLD, instead of FILL. HOLD keeps the program and prog_len, with busy=0 and s_ready=1.
  - In HOLD, replay=1 starts BURST again from address 0 with the same prog_len; replay has priority over s_valid in the same cycle.
  - In HOLD, a handshake with replay=0 discards the stored program: write pointer resets to 0, the word is written at entry 0, and the state moves to FILL.
- Not defined: no HOLD state; the replay input is ignored.

Test Plan:
- Load 3 words 0x11, 0x22, 0x33 (s_last on 0x33), then hold exec_v low → inst_out_v high exactly 3 cycles with 0x11, 0x22, 0x33; first valid 2 cycles after the s_last beat; prog_len=3; busy stays 1 and s_ready stays 0.
- Continue from above: pulse exec_v high for 5 cycles, then low → FILL reached, s_ready=1; a second program of 2 words emits only its 2 words, with no stale 0x33.
- Send 16 words with no s_last (DEPTH=16) → burst of 16, trunc_err=1; it stays 1 through the next program and clears only on rst_n.
- Single beat 0xABCD with s_last → one inst_out_v cycle carrying 0xABCD; prog_len=1.
- Assert rst_n low on the 2nd burst cycle of a 4-word program → inst_out_v=0 immediately; after release, s_ready=1 and a new 2-word program bursts exactly 2 words.
- With INST_LOADER_REPLAY_EN: load 0x5, 0x6, run an exec_v pulse, then pulse replay → burst 0x5, 0x6 again; in HOLD, an s_valid beat 0x9 with s_last → next burst is only 0x9.
